layer_sequencer: RTL

Controller that runs one fully-connected layer over the pixel and weight RAMs loaded by `avalon_interface`. When `start_calc` is pulsed, it walks the pixel and weight addresses and performs a signed multiply-accumulate per output neuron. Each saturated result is written to the output register slot addressed by `output_address`, and `done_calc` is pulsed on completion. It sits between `avalon_interface` (control and result path) and the two synchronous on-chip RAMs (read ports).

---
 rtl/nn_pkg.sv | 41 ++++
 rtl/mac_unit.sv | 78 +++++++
 rtl/layer_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, sequencer state encoding and the result
// saturation helper for the fully-connected layer datapath.
//
// Contents:
//   ADDR_W, DATA_W, RESULT_W, OUT_ADDR_W, ACC_W  - datapath widths
//   seq_state_t                                  - layer_sequencer FSM states
//   saturate_acc()                               - clamp 40-bit acc to 17 bits
package nn_pkg;

    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 16;
    localparam int RESULT_W   = 17;
    localparam int OUT_ADDR_W = 4;
    localparam int ACC_W      = 40;

    // Clamp bounds of the signed 17-bit result range
    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd65535;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd65536;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Saturate a signed accumulator value into the signed 17-bit result range
    function automatic logic [RESULT_W-1:0] saturate_acc(input logic signed [ACC_W-1:0] acc_value);
        logic [RESULT_W-1:0] sat_value;
        if (acc_value > SAT_MAX) begin
            sat_value = 17'h0FFFF;
        end else if (acc_value < SAT_MIN) begin
            sat_value = 17'h10000;
        end else begin
            sat_value = acc_value[RESULT_W-1:0];
        end
        return sat_value;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// mac_unit: signed 16x16 multiply-accumulate with a 40-bit accumulator,
// saturation to 17 bits and an optional ReLU on the saturated result.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   clr          - clear the accumulator on this edge (has priority over en)
//   en           - add pixel_data*weight_data into the accumulator
//   pixel_data   - signed 16-bit pixel
//   weight_data  - signed 16-bit weight
//   result       - saturated (and optionally rectified) value of the
//                  accumulator *including* the product being added this
//                  cycle, so the caller can register it on the edge that
//                  folds in the last product.
//
// Build option: define LAYER_SEQ_RELU_EN to replace negative results by 0.
module mac_unit
    import nn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [DATA_W-1:0]   pixel_data,
    input  logic [DATA_W-1:0]   weight_data,
    output logic [RESULT_W-1:0] result
);

    logic signed [2*DATA_W-1:0] pixel_ext_s;
    logic signed [2*DATA_W-1:0] weight_ext_s;
    logic signed [2*DATA_W-1:0] product_s;
    logic signed [ACC_W-1:0]    product_ext_s;
    logic signed [ACC_W-1:0]    acc_next_s;
    logic signed [ACC_W-1:0]    acc_r;
    logic [RESULT_W-1:0]        sat_s;

    // Multiply-add and saturation of the next accumulator value
    always_comb begin
        pixel_ext_s   = {{DATA_W{pixel_data[DATA_W-1]}}, pixel_data};
        weight_ext_s  = {{DATA_W{weight_data[DATA_W-1]}}, weight_data};
        // A 16x16 signed product always fits in 32 bits, so truncation is exact
        product_s     = pixel_ext_s * weight_ext_s;
        product_ext_s = {{(ACC_W-2*DATA_W){product_s[2*DATA_W-1]}}, product_s};
        if (en) begin
            acc_next_s = acc_r + product_ext_s;
        end else begin
            acc_next_s = acc_r;
        end
        sat_s = saturate_acc(acc_next_s);
    end

`ifdef LAYER_SEQ_RELU_EN
    // Rectify: negative saturated results become zero
    always_comb begin
        if (sat_s[RESULT_W-1]) begin
            result = {RESULT_W{1'b0}};
        end else begin
            result = sat_s;
        end
    end
`else
    // Signed saturated result passes through unchanged
    always_comb begin
        result = sat_s;
    end
`endif

    // Accumulator register with clear priority over accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= 40'sd0;
        end else if (clr) begin
            acc_r <= 40'sd0;
        end else begin
            acc_r <= acc_next_s;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs one fully-connected layer over the pixel and weight
// RAMs. On start_calc it reads NUM_IN pixel/weight pairs per output neuron,
// accumulates their signed products in mac_unit, writes each saturated
// result to output slot o, and pulses done_calc after the last neuron.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   start_calc                    - start request, honoured only in IDLE
//   pixel_data, weight_data       - RAM read data, valid one cycle after rd_en
//   pixel_address, weight_address - RAM read addresses
//   rd_en                         - read strobe for both RAMs
//   result_output, output_address - neuron result and its slot index
//   result_valid                  - one-cycle write strobe per neuron
//   done_calc                     - one-cycle completion pulse
//   busy                          - high whenever the FSM is not IDLE
//
// Build option: LAYER_SEQ_RELU_EN (see mac_unit) rectifies results.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_IN  = 64,
    parameter int NUM_OUT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_calc,
    input  logic [DATA_W-1:0]     pixel_data,
    input  logic [DATA_W-1:0]     weight_data,
    output logic [ADDR_W-1:0]     pixel_address,
    output logic [ADDR_W-1:0]     weight_address,
    output logic                  rd_en,
    output logic [RESULT_W-1:0]   result_output,
    output logic [OUT_ADDR_W-1:0] output_address,
    output logic                  result_valid,
    output logic                  done_calc,
    output logic                  busy
);

    localparam logic [ADDR_W-1:0]     LAST_I  = ADDR_W'(NUM_IN - 1);
    localparam logic [ADDR_W-1:0]     IN_STEP = ADDR_W'(NUM_IN);
    localparam logic [OUT_ADDR_W-1:0] LAST_O  = OUT_ADDR_W'(NUM_OUT - 1);

    seq_state_t            state_r;
    logic [ADDR_W-1:0]     i_r;
    logic [OUT_ADDR_W-1:0] o_r;
    // o_r*NUM_IN, kept as a running base so no multiplier is needed
    logic [ADDR_W-1:0]     wbase_r;
    logic                  data_vld_r;
    logic                  acc_clr_s;
    logic [RESULT_W-1:0]   mac_result_s;

    mac_unit u_mac (
        .clk         (clk),
        .rst         (rst),
        .clr         (acc_clr_s),
        .en          (data_vld_r),
        .pixel_data  (pixel_data),
        .weight_data (weight_data),
        .result      (mac_result_s)
    );

    // Accumulator clear on every edge that enters RUN for a new neuron
    always_comb begin
        acc_clr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_calc) begin
                    acc_clr_s = 1'b1;
                end else begin
                    acc_clr_s = 1'b0;
                end
            end
            ST_WRITE: begin
                if (o_r != LAST_O) begin
                    acc_clr_s = 1'b1;
                end else begin
                    acc_clr_s = 1'b0;
                end
            end
            default: acc_clr_s = 1'b0;
        endcase
    end

    // Sequencer FSM; outputs are registered and loaded one edge ahead so
    // that they are valid in the cycle of the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            i_r            <= 11'd0;
            o_r            <= 4'd0;
            wbase_r        <= 11'd0;
            data_vld_r     <= 1'b0;
            pixel_address  <= 11'd0;
            weight_address <= 11'd0;
            rd_en          <= 1'b0;
            result_output  <= 17'd0;
            output_address <= 4'd0;
            result_valid   <= 1'b0;
            done_calc      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            // Read data returns one cycle after the strobe
            data_vld_r   <= rd_en;
            result_valid <= 1'b0;
            done_calc    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_calc) begin
                        state_r        <= ST_RUN;
                        i_r            <= 11'd0;
                        o_r            <= 4'd0;
                        wbase_r        <= 11'd0;
                        pixel_address  <= 11'd0;
                        weight_address <= 11'd0;
                        rd_en          <= 1'b1;
                        busy           <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (i_r == LAST_I) begin
                        state_r <= ST_DRAIN;
                        rd_en   <= 1'b0;
                    end else begin
                        i_r            <= i_r + 11'd1;
                        pixel_address  <= i_r + 11'd1;
                        weight_address <= wbase_r + i_r + 11'd1;
                        rd_en          <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The last product is folded in on this edge; mac_result_s
                    // already includes it, so capture it now for WRITE.
                    state_r        <= ST_WRITE;
                    result_output  <= mac_result_s;
                    output_address <= o_r;
                    result_valid   <= 1'b1;
                end
                ST_WRITE: begin
                    if (o_r == LAST_O) begin
                        state_r   <= ST_DONE;
                        done_calc <= 1'b1;
                    end else begin
                        state_r        <= ST_RUN;
                        o_r            <= o_r + 4'd1;
                        i_r            <= 11'd0;
                        wbase_r        <= wbase_r + IN_STEP;
                        pixel_address  <= 11'd0;
                        weight_address <= wbase_r + IN_STEP;
                        rd_en          <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    rd_en   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
